// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage register.
//   NOP_INSTR          - default bubble encoding for processor stage registers
//   OCC_EMPTY/ONE/FULL - values reported on the occupancy port
//   occ_state_e        - stage state decoded from the slot valid bits
package pipe_pkg;

   localparam logic [15:0] NOP_INSTR = 16'h0000;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   typedef enum logic [1:0] {
      StEmpty,
      StOne,
      StFull
   } occ_state_e;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one storage entry (data register plus valid bit).
//   clk, reset : clock, asynchronous active-low reset
//   load       : write d into the slot and mark it valid
//   clear      : mark the slot invalid (wins over load; data is left untouched)
//   d          : write data
//   q, v       : stored data and valid bit
module pipe_slot #(
   parameter int unsigned       DATA_W = 16,
   parameter logic [DATA_W-1:0] BUBBLE = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q,
   output logic              v
);

   logic [DATA_W-1:0] data_q, data_d;
   logic              v_q, v_d;

   always_comb begin
      data_d = data_q;
      v_d    = v_q;
      if (clear) begin
         v_d = 1'b0;
      end else if (load) begin
         data_d = d;
         v_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q <= BUBBLE;
         v_q    <= 1'b0;
      end else begin
         data_q <= data_d;
         v_q    <= v_d;
      end
   end

   assign q = data_q;
   assign v = v_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake,
// synchronous flush and an optional skid entry.
// Build option: define PIPE_STAGE_SKID_EN to add the skid slot S and make
// in_ready a pure register output (!S.v). Without it only slot M exists and
// in_ready = !M.v || out_ready.
//   clk, reset          : clock, asynchronous active-low reset
//   flush               : drop all held entries and any same-cycle input
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data head or BUBBLE
//   occupancy           : number of held entries
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W = 16,
   parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP_INSTR)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic              accept, consume;
   logic              m_load, m_clear, m_v;
   logic [DATA_W-1:0] m_d, m_q;
   logic              s_v;
   occ_state_e        state;

   pipe_slot #(
      .DATA_W(DATA_W),
      .BUBBLE(BUBBLE)
   ) u_slot_m (
      .clk  (clk),
      .reset(reset),
      .load (m_load),
      .clear(m_clear),
      .d    (m_d),
      .q    (m_q),
      .v    (m_v)
   );

`ifdef PIPE_STAGE_SKID_EN
   logic              s_load, s_clear;
   logic [DATA_W-1:0] s_q;

   pipe_slot #(
      .DATA_W(DATA_W),
      .BUBBLE(BUBBLE)
   ) u_slot_s (
      .clk  (clk),
      .reset(reset),
      .load (s_load),
      .clear(s_clear),
      .d    (in_data),
      .q    (s_q),
      .v    (s_v)
   );

   // Registered ready: no path from out_ready, one spare entry absorbs the stall.
   assign in_ready = !s_v;
`else
   assign s_v      = 1'b0;
   assign in_ready = !m_v || out_ready;
`endif

   assign accept    = in_valid && in_ready;
   assign consume   = m_v && out_ready;
   assign out_valid = m_v;
   assign out_data  = m_v ? m_q : BUBBLE;

   // S is only ever valid behind a valid M, so two bits fully decode the state.
   always_comb begin
      state = StEmpty;
      if (s_v)      state = StFull;
      else if (m_v) state = StOne;
   end

   always_comb begin
      m_load  = 1'b0;
      m_clear = 1'b0;
      m_d     = in_data;
`ifdef PIPE_STAGE_SKID_EN
      s_load  = 1'b0;
      s_clear = 1'b0;
`endif
      if (flush) begin
         // Same-cycle accept is dropped; a same-cycle consume still completes.
         m_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
         s_clear = 1'b1;
`endif
      end else begin
         unique case (state)
            StEmpty: begin
               if (accept) m_load = 1'b1;
            end
            StOne: begin
               if (accept) begin
`ifdef PIPE_STAGE_SKID_EN
                  if (consume) m_load = 1'b1;
                  else         s_load = 1'b1;
`else
                  // Without skid, accepting while M is valid implies a consume.
                  m_load = 1'b1;
`endif
               end else if (consume) begin
                  m_clear = 1'b1;
               end
            end
            StFull: begin
`ifdef PIPE_STAGE_SKID_EN
               if (consume) begin
                  m_load  = 1'b1;
                  m_d     = s_q;
                  s_clear = 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end
   end

`ifdef PIPE_STAGE_SKID_EN
   always_comb begin
      unique case (state)
         StFull:  occupancy = OCC_FULL;
         StOne:   occupancy = OCC_ONE;
         default: occupancy = OCC_EMPTY;
      endcase
   end
`else
   assign occupancy = m_v ? OCC_ONE : OCC_EMPTY;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg.
// Skid-specific scenarios follow the PIPE_STAGE_SKID_EN build option.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst_a, flush_a, in_valid_a, out_ready_a;
   logic [15:0] in_data_a;
   logic        in_ready_a, out_valid_a;
   logic [15:0] out_data_a;
   logic [1:0]  occ_a;

   logic        rst_b, flush_b, in_valid_b, out_ready_b;
   logic [31:0] in_data_b;
   logic        in_ready_b, out_valid_b;
   logic [31:0] out_data_b;
   logic [1:0]  occ_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_stage_reg u_dut_a (
      .clk      (clk),
      .reset    (rst_a),
      .flush    (flush_a),
      .in_valid (in_valid_a),
      .in_ready (in_ready_a),
      .in_data  (in_data_a),
      .out_valid(out_valid_a),
      .out_ready(out_ready_a),
      .out_data (out_data_a),
      .occupancy(occ_a)
   );

   pipe_stage_reg #(
      .DATA_W(32),
      .BUBBLE(32'h0000_F000)
   ) u_dut_b (
      .clk      (clk),
      .reset    (rst_b),
      .flush    (flush_b),
      .in_valid (in_valid_b),
      .in_ready (in_ready_b),
      .in_data  (in_data_b),
      .out_valid(out_valid_b),
      .out_ready(out_ready_b),
      .out_data (out_data_b),
      .occupancy(occ_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = 1'b0; flush_a = 1'b0; in_valid_a = 1'b1; in_data_a = 16'hABCD;
      out_ready_a = 1'b1;
      rst_b = 1'b0; flush_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
      out_ready_b = 1'b0;

      // Reset with input offered.
      #12;
      check("rst_out_valid", 32'(out_valid_a), 32'd0);
      check("rst_out_data", 32'(out_data_a), 32'h0000);
      check("rst_in_ready", 32'(in_ready_a), 32'd1);
      check("rst_occ", 32'(occ_a), 32'd0);
      rst_a = 1'b1;
      step();
      check("rel_out_data", 32'(out_data_a), 32'hABCD);
      check("rel_out_valid", 32'(out_valid_a), 32'd1);
      check("rel_occ", 32'(occ_a), 32'd1);
      in_valid_a = 1'b0;
      step();
      check("drain_valid", 32'(out_valid_a), 32'd0);
      check("drain_bubble", 32'(out_data_a), 32'h0000);

      // Continuous stream, one per cycle.
      for (int i = 1; i <= 8; i++) begin
         in_valid_a = 1'b1;
         in_data_a  = 16'(i);
         step();
         check("stream_data", 32'(out_data_a), 32'(i));
         check("stream_valid", 32'(out_valid_a), 32'd1);
         check("stream_occ", 32'(occ_a), 32'd1);
      end
      in_valid_a = 1'b0;
      step();
      check("stream_end", 32'(out_valid_a), 32'd0);

`ifdef PIPE_STAGE_SKID_EN
      // Skid absorbs one extra entry, then back-pressure holds 0x33.
      out_ready_a = 1'b0;
      in_valid_a = 1'b1; in_data_a = 16'h0011;
      step();
      check("skid_occ1", 32'(occ_a), 32'd1);
      check("skid_rdy1", 32'(in_ready_a), 32'd1);
      in_data_a = 16'h0022;
      step();
      check("skid_occ2", 32'(occ_a), 32'd2);
      check("skid_rdy0", 32'(in_ready_a), 32'd0);
      check("skid_head", 32'(out_data_a), 32'h0011);
      in_data_a = 16'h0033;
      step();
      check("skid_hold_occ", 32'(occ_a), 32'd2);
      check("skid_hold_head", 32'(out_data_a), 32'h0011);
      out_ready_a = 1'b1;
      step();
      check("skid_ord2", 32'(out_data_a), 32'h0022);
      check("skid_rdy_back", 32'(in_ready_a), 32'd1);
      check("skid_occ_back", 32'(occ_a), 32'd1);
      step();
      check("skid_ord3", 32'(out_data_a), 32'h0033);
      in_valid_a = 1'b0;
      step();
      check("skid_empty", 32'(out_valid_a), 32'd0);

      // Flush while FULL with input offered.
      out_ready_a = 1'b0;
      in_valid_a = 1'b1; in_data_a = 16'h0011;
      step();
      in_data_a = 16'h0022;
      step();
      check("fl_full", 32'(occ_a), 32'd2);
      flush_a = 1'b1; in_data_a = 16'h0044;
`else
      // No skid: ready follows out_ready combinationally when M is full.
      out_ready_a = 1'b0;
      in_valid_a = 1'b1; in_data_a = 16'h0055;
      step();
      check("ns_occ", 32'(occ_a), 32'd1);
      in_data_a = 16'h0066;
      #1;
      check("ns_rdy0", 32'(in_ready_a), 32'd0);
      step();
      check("ns_hold", 32'(out_data_a), 32'h0055);
      out_ready_a = 1'b1;
      #1;
      check("ns_rdy_comb", 32'(in_ready_a), 32'd1);
      step();
      check("ns_load", 32'(out_data_a), 32'h0066);
      in_valid_a = 1'b0;
      step();
      check("ns_empty", 32'(out_valid_a), 32'd0);

      // Flush while M is full with input offered.
      out_ready_a = 1'b0;
      in_valid_a = 1'b1; in_data_a = 16'h0011;
      step();
      check("fl_full", 32'(occ_a), 32'd1);
      flush_a = 1'b1; in_data_a = 16'h0044;
`endif
      step();
      check("fl_occ", 32'(occ_a), 32'd0);
      check("fl_valid", 32'(out_valid_a), 32'd0);
      check("fl_bubble", 32'(out_data_a), 32'h0000);
      // Flush from empty with a live handshake: entry is dropped.
      out_ready_a = 1'b1;
      #1;
      check("fl_rdy", 32'(in_ready_a), 32'd1);
      step();
      check("fl_drop", 32'(out_valid_a), 32'd0);
      flush_a = 1'b0; in_valid_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("fl_never_44", 32'(out_valid_a), 32'd0);
      end

      // Wide instance with custom bubble, async reset mid-stream.
      check("b_rst_bubble", out_data_b, 32'h0000_F000);
      check("b_rst_rdy", 32'(in_ready_b), 32'd1);
      rst_b = 1'b1;
      out_ready_b = 1'b0;
      in_valid_b = 1'b1; in_data_b = 32'h1234_5678;
      step();
      check("b_data", out_data_b, 32'h1234_5678);
      in_valid_b = 1'b0;
      #2;
      rst_b = 1'b0;
      #1;
      check("b_async_valid", 32'(out_valid_b), 32'd0);
      check("b_async_bubble", out_data_b, 32'h0000_F000);
      check("b_async_occ", 32'(occ_b), 32'd0);
      #3;
      rst_b = 1'b1;
      step();
      check("b_post_rel", out_data_b, 32'h0000_F000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
